spectrum_peak_classifier: RTL and testbench

Upstream of the per-channel PLL stages. Consumes one FFT power-spectrum frame per analysis cycle and locates the two dominant fundamentals. It classifies each fundamental as sine or triangle using its 3rd-harmonic power, then presents per-channel DDS frequency words, the 2-bit waveform code and peak powers that seed both PLLs. Results update atomically once per good frame and hold between frames.

---
 rtl/sig_sep_pkg.sv | 26 ++
 rtl/spectrum_peak_classifier_if.sv | 18 +
 rtl/spec_ram.sv | 33 +++
 rtl/spectrum_peak_classifier.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_spectrum_peak_classifier.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sig_sep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sig_sep_pkg
// Description : Shared types and constants for the peak classifier and PLLs.
// Revision    : 1.0 - initial release
// ============================================================================
package sig_sep_pkg;

  localparam int FRE_W = 48;

  // tri_judge bit positions, also consumed by the PLL stage
  localparam int TRI_A = 0;
  localparam int TRI_B = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SCAN_A  = 3'd2,
    ST_SCAN_B  = 3'd3,
    ST_HARM    = 3'd4,
    ST_CALC    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spectrum_peak_classifier_if.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_peak_classifier_if
// Description : Power-spectrum stream (tdata/tvalid/tlast/tready).
// Revision    : 1.0 - initial release
// ============================================================================
interface spectrum_peak_classifier_if #(
  parameter int MAG_W = 32
) ();
  logic [MAG_W-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/spec_ram.sv
`default_nettype none
// ============================================================================
// Module      : spec_ram
// Description : Simple dual-port spectrum store, one write port, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module spec_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_re,
  input  wire logic [AW-1:0]    i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/spectrum_peak_classifier.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_peak_classifier
// Description : Finds the two dominant spectral peaks, classifies sine/triangle
//               from 3rd-harmonic power and emits DDS words for both PLLs.
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_peak_classifier
  import sig_sep_pkg::*;
#(
  parameter int                 FFT_LEN   = 1024,
  parameter int                 MAG_W     = 32,
  parameter int                 MIN_BIN   = 2,
  parameter int                 GUARD     = 2,
  parameter int                 THR_SHIFT = 7,
  parameter longint unsigned    MIN_MAG   = 1024,
  parameter logic [FRE_W-1:0]   FRE_STEP  = 48'h0000_8000_0000
) (
  input  wire logic               sys_clk,
  input  wire logic               sys_rst,
  spectrum_peak_classifier_if.slave s_mag,
  output logic      [FRE_W-1:0]   fre_a,
  output logic      [FRE_W-1:0]   fre_b,
  output logic      [1:0]         tri_judge,
  output logic      [63:0]        power,
  output logic                    result_valid,
  output logic                    frame_err
);

  localparam int c_HALF  = FFT_LEN / 2;
  localparam int c_AW    = $clog2(c_HALF);
  localparam int c_CW    = $clog2(FFT_LEN);
  localparam int c_HW    = c_AW + 2;
  localparam int c_CMP_W = MAG_W + THR_SHIFT;

  localparam logic [c_CW-1:0]  c_LAST_BIN  = c_CW'(FFT_LEN - 1);
  localparam logic [c_CW-1:0]  c_HALF_CW   = c_CW'(c_HALF);
  localparam logic [c_CW-1:0]  c_SCAN_N    = c_CW'(c_HALF - MIN_BIN);
  localparam logic [c_CW-1:0]  c_SCAN_LAST = c_CW'(c_HALF - MIN_BIN + 1);
  localparam logic [c_HW-1:0]  c_HALF_HW   = c_HW'(c_HALF);
  localparam logic [c_AW-1:0]  c_MIN_BIN   = c_AW'(MIN_BIN);
  localparam logic [c_AW-1:0]  c_GUARD     = c_AW'(GUARD);
  localparam logic [MAG_W-1:0] c_MIN_MAG   = MAG_W'(MIN_MAG);

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CW-1:0]  r_bin_cnt;
  logic [c_CW-1:0]  r_step;
  logic             w_ready;
  logic             w_beat;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [c_AW-1:0]  w_rd_addr;
  logic [c_AW-1:0]  w_scan_addr;
  logic [MAG_W-1:0] w_rd_data;
  logic             w_err;
  logic             w_low;

  logic             r_rd_vld;
  logic [c_AW-1:0]  r_rd_idx;
  logic [MAG_W-1:0] r_max;
  logic [c_AW-1:0]  r_max_idx;
  logic [c_AW-1:0]  w_dist;
  logic             w_excl;

  logic [c_AW-1:0]  r_ka;
  logic [c_AW-1:0]  r_kb;
  logic [MAG_W-1:0] r_pa;
  logic [MAG_W-1:0] r_pb;
  logic [MAG_W-1:0] r_harm_a;
  logic [MAG_W-1:0] r_harm_b;
  logic [c_HW-1:0]  w_h3a;
  logic [c_HW-1:0]  w_h3b;
  logic             w_h3a_in;
  logic             w_h3b_in;
  logic             w_tri_a;
  logic             w_tri_b;
  logic             w_a_lo;

  logic [c_AW-1:0]  r_lo_k;
  logic [c_AW-1:0]  r_hi_k;
  logic [MAG_W-1:0] r_lo_p;
  logic [MAG_W-1:0] r_hi_p;
  logic             r_lo_tri;
  logic             r_hi_tri;
  logic [FRE_W-1:0] r_fre_lo;
  logic [FRE_W-1:0] r_fre_hi;

  spec_ram #(
    .DEPTH (c_HALF),
    .WIDTH (MAG_W)
  ) u_spec_ram (
    .clk     (sys_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_bin_cnt[c_AW-1:0]),
    .i_wdata (s_mag.tdata),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign s_mag.tready = w_ready;
  assign w_beat       = s_mag.tvalid & w_ready;
  assign w_scan_addr  = c_MIN_BIN + r_step[c_AW-1:0];

  // Harmonic bins are wider than the RAM address so out-of-range 3k is visible
  assign w_h3a    = ({2'b00, r_ka} << 1) + {2'b00, r_ka};
  assign w_h3b    = ({2'b00, r_kb} << 1) + {2'b00, r_kb};
  assign w_h3a_in = (w_h3a < c_HALF_HW);
  assign w_h3b_in = (w_h3b < c_HALF_HW);

  assign w_dist = (r_rd_idx >= r_ka) ? (r_rd_idx - r_ka) : (r_ka - r_rd_idx);
  assign w_excl = (r_state == ST_SCAN_B) && (w_dist <= c_GUARD);
  assign w_low  = (r_pa < c_MIN_MAG) || (r_max < c_MIN_MAG);

  assign w_tri_a = ((c_CMP_W'(r_harm_a)) << THR_SHIFT) >= c_CMP_W'(r_pa);
  assign w_tri_b = ((c_CMP_W'(r_harm_b)) << THR_SHIFT) >= c_CMP_W'(r_pb);
  assign w_a_lo  = (r_ka < r_kb);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = w_scan_addr;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE, ST_CAPTURE: begin
        w_ready = 1'b1;
        if (s_mag.tvalid) begin
          w_wr_en = (r_bin_cnt < c_HALF_CW);
          if (s_mag.tlast && (r_bin_cnt == c_LAST_BIN)) begin
            w_state_nxt = ST_SCAN_A;
          end else if (s_mag.tlast || (r_bin_cnt == c_LAST_BIN)) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end
      end
      ST_SCAN_A: begin
        w_rd_en = (r_step < c_SCAN_N);
        if (r_step == c_SCAN_LAST) begin
          w_state_nxt = ST_SCAN_B;
        end
      end
      ST_SCAN_B: begin
        w_rd_en = (r_step < c_SCAN_N);
        if (r_step == c_SCAN_LAST) begin
          if (w_low) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HARM;
          end
        end
      end
      ST_HARM: begin
        if (r_step == c_CW'(0)) begin
          w_rd_en   = w_h3a_in;
          w_rd_addr = w_h3a[c_AW-1:0];
        end else begin
          w_rd_en   = (r_step == c_CW'(1)) && w_h3b_in;
          w_rd_addr = w_h3b[c_AW-1:0];
        end
        if (r_step == c_CW'(2)) begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_step == c_CW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_bin_cnt    <= '0;
      r_step       <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_idx     <= '0;
      r_max        <= '0;
      r_max_idx    <= c_MIN_BIN;
      r_ka         <= '0;
      r_kb         <= '0;
      r_pa         <= '0;
      r_pb         <= '0;
      r_harm_a     <= '0;
      r_harm_b     <= '0;
      r_lo_k       <= '0;
      r_hi_k       <= '0;
      r_lo_p       <= '0;
      r_hi_p       <= '0;
      r_lo_tri     <= 1'b0;
      r_hi_tri     <= 1'b0;
      r_fre_lo     <= '0;
      r_fre_hi     <= '0;
      fre_a        <= '0;
      fre_b        <= '0;
      tri_judge    <= '0;
      power        <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      frame_err    <= w_err;

      if (w_beat) begin
        r_bin_cnt <= (s_mag.tlast || (r_bin_cnt == c_LAST_BIN)) ? '0 : r_bin_cnt + 1'b1;
      end

      r_step   <= (w_state_nxt != r_state) ? '0 : r_step + 1'b1;
      r_rd_vld <= w_rd_en && ((r_state == ST_SCAN_A) || (r_state == ST_SCAN_B));
      r_rd_idx <= w_rd_addr;

      // Strict '>' keeps the lowest-index bin on ties
      if ((r_state == ST_IDLE) || (r_state == ST_CAPTURE)) begin
        r_max     <= '0;
        r_max_idx <= c_MIN_BIN;
      end else if ((r_state == ST_SCAN_A) && (r_step == c_SCAN_LAST)) begin
        r_ka      <= r_max_idx;
        r_pa      <= r_max;
        r_max     <= '0;
        r_max_idx <= c_MIN_BIN;
      end else if ((r_state == ST_SCAN_B) && (r_step == c_SCAN_LAST)) begin
        r_kb <= r_max_idx;
        r_pb <= r_max;
      end else if (((r_state == ST_SCAN_A) || (r_state == ST_SCAN_B)) && r_rd_vld
                   && !w_excl && (w_rd_data > r_max)) begin
        r_max     <= w_rd_data;
        r_max_idx <= r_rd_idx;
      end

      if (r_state == ST_HARM) begin
        if (r_step == c_CW'(1)) begin
          r_harm_a <= w_h3a_in ? w_rd_data : '0;
        end
        if (r_step == c_CW'(2)) begin
          r_harm_b <= w_h3b_in ? w_rd_data : '0;
        end
      end

      if (r_state == ST_CALC) begin
        if (r_step == c_CW'(0)) begin
          r_lo_k   <= w_a_lo ? r_ka    : r_kb;
          r_hi_k   <= w_a_lo ? r_kb    : r_ka;
          r_lo_p   <= w_a_lo ? r_pa    : r_pb;
          r_hi_p   <= w_a_lo ? r_pb    : r_pa;
          r_lo_tri <= w_a_lo ? w_tri_a : w_tri_b;
          r_hi_tri <= w_a_lo ? w_tri_b : w_tri_a;
        end else begin
          r_fre_lo <= FRE_W'(r_lo_k) * FRE_STEP;
          r_fre_hi <= FRE_W'(r_hi_k) * FRE_STEP;
        end
      end

      if (r_state == ST_DONE) begin
        fre_a            <= r_fre_lo;
        fre_b            <= r_fre_hi;
        tri_judge[TRI_A] <= r_lo_tri;
        tri_judge[TRI_B] <= r_hi_tri;
        power            <= {32'(r_lo_p), 32'(r_hi_p)};
        result_valid     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spectrum_peak_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_spectrum_peak_classifier
// Description : Randomised frames checked against a behavioural peak model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectrum_peak_classifier;

  localparam int           FFT_LEN   = 1024;
  localparam int           MAG_W     = 32;
  localparam int           MIN_BIN   = 2;
  localparam int           GUARD     = 2;
  localparam int           THR_SHIFT = 7;
  localparam longint       MIN_MAG   = 1024;
  localparam logic [47:0]  FRE_STEP  = 48'h0000_8000_0000;
  localparam int           HALF      = FFT_LEN / 2;
  localparam int           LAT       = 1031;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spectrum_peak_classifier_if #(.MAG_W(MAG_W)) mag_if ();

  logic [47:0] fre_a, fre_b;
  logic [1:0]  tri_judge;
  logic [63:0] power;
  logic        result_valid, frame_err;

  spectrum_peak_classifier #(
    .FFT_LEN   (FFT_LEN),
    .MAG_W     (MAG_W),
    .MIN_BIN   (MIN_BIN),
    .GUARD     (GUARD),
    .THR_SHIFT (THR_SHIFT),
    .MIN_MAG   (MIN_MAG),
    .FRE_STEP  (FRE_STEP)
  ) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .s_mag        (mag_if),
    .fre_a        (fre_a),
    .fre_b        (fre_b),
    .tri_judge    (tri_judge),
    .power        (power),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [MAG_W-1:0] frame [FFT_LEN];
  logic [47:0]      exp_fa, exp_fb, h_fa, h_fb;
  logic [1:0]       exp_tri, h_tri;
  logic [63:0]      exp_pow, h_pow;
  bit               exp_bad;

  // Reference: argmax, guarded second argmax, harmonic test, then order by bin
  task automatic model();
    int ka, kb, lo, hi;
    longint unsigned pa, pb, ha, hb, plo, phi;
    bit ta, tb, tlo, thi;
    ka = MIN_BIN;
    pa = frame[MIN_BIN];
    for (int k = MIN_BIN + 1; k < HALF; k++)
      if (frame[k] > pa) begin ka = k; pa = frame[k]; end
    kb = -1;
    pb = 0;
    for (int k = MIN_BIN; k < HALF; k++) begin
      if ((k - ka <= GUARD) && (ka - k <= GUARD)) continue;
      if (kb < 0 || frame[k] > pb) begin kb = k; pb = frame[k]; end
    end
    exp_bad = (pa < MIN_MAG) || (pb < MIN_MAG);
    ha = (3 * ka < HALF) ? longint'(frame[3 * ka]) : 0;
    hb = (3 * kb < HALF) ? longint'(frame[3 * kb]) : 0;
    ta = (ha * 128) >= pa;
    tb = (hb * 128) >= pb;
    if (ka < kb) begin lo = ka; hi = kb; plo = pa; phi = pb; tlo = ta; thi = tb; end
    else         begin lo = kb; hi = ka; plo = pb; phi = pa; tlo = tb; thi = ta; end
    exp_fa  = 48'(longint'(lo) * longint'(FRE_STEP));
    exp_fb  = 48'(longint'(hi) * longint'(FRE_STEP));
    exp_tri = {thi, tlo};
    exp_pow = {32'(plo), 32'(phi)};
  endtask

  task automatic fill(input int id);
    int k1, k2;
    for (int k = 0; k < FFT_LEN; k++)
      frame[k] = (k >= HALF) ? $urandom : ((id >= 5) ? $urandom_range(0, 5000) : 32'd10);
    case (id)
      0: begin frame[20] = 1000000; frame[70] = 1000000; end
      1: begin frame[20] = 1000000; frame[60] = 12346; frame[35] = 800000; end
      2: begin frame[100] = 1000000; frame[300] = 12345; frame[40] = 900000; end
      3: begin frame[200] = 1000000; frame[50] = 700000; end
      4: begin frame[30] = 1000000; frame[31] = 1000000; frame[29] = 900000;
               frame[33] = 300000; frame[80] = 500000; end
      default: begin
        k1 = $urandom_range(MIN_BIN, HALF - 1);
        k2 = $urandom_range(MIN_BIN, HALF - 1);
        frame[k1] = $urandom_range(2000, 3000000);
        frame[k2] = $urandom_range(2000, 3000000);
        if (3 * k1 < HALF) frame[3 * k1] = (frame[k1] >> 7) + $urandom_range(0, 2) - 1;
        if (3 * k2 < HALF && $urandom_range(0, 1) == 1)
          frame[3 * k2] = (frame[k2] >> 7) + $urandom_range(0, 2) - 1;
      end
    endcase
  endtask

  task automatic send_frame(input int n_beats);
    int guard_cnt;
    for (int i = 0; i < n_beats; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mag_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      mag_if.tdata  = frame[i];
      mag_if.tvalid = 1'b1;
      mag_if.tlast  = (i == n_beats - 1);
      guard_cnt = 0;
      while (!mag_if.tready && guard_cnt < 3000) begin
        @(posedge clk); #1;
        guard_cnt++;
      end
      if (guard_cnt >= 3000) begin
        n_err++;
        $display("FAIL tready_timeout: tready stayed %0b, required 1", mag_if.tready);
      end
      @(posedge clk); #1;
    end
    mag_if.tvalid = 1'b0;
    mag_if.tlast  = 1'b0;
  endtask

  // Latency is counted from the cycle the tlast beat was presented
  task automatic wait_outcome(output int lat, output bit got_rv, output bit got_err);
    int n;
    n = 0;
    got_rv = 0;
    got_err = 0;
    lat = 1;
    if (frame_err) begin got_err = 1; return; end
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (result_valid) begin got_rv = 1; break; end
      if (frame_err) begin got_err = 1; break; end
    end
    lat = n + 1;
  endtask

  task automatic test_reset();
    mag_if.tdata = '0; mag_if.tvalid = 1'b0; mag_if.tlast = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (fre_a !== 48'd0) begin n_err++; $display("FAIL reset_fre_a: got %0h required 0", fre_a); end
    n_vec++; if (fre_b !== 48'd0) begin n_err++; $display("FAIL reset_fre_b: got %0h required 0", fre_b); end
    n_vec++; if (tri_judge !== 2'd0) begin n_err++; $display("FAIL reset_tri: got %0b required 0", tri_judge); end
    n_vec++; if (power !== 64'd0) begin n_err++; $display("FAIL reset_power: got %0h required 0", power); end
    n_vec++; if (result_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: got rv=%0b err=%0b required 0/0", result_valid, frame_err); end
    n_vec++; if (mag_if.tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %0b required 1", mag_if.tready); end
    h_fa = '0; h_fb = '0; h_tri = '0; h_pow = '0;
  endtask

  task automatic test_peak_frame(input int id);
    int lat;
    bit rv, er;
    fill(id);
    model();
    send_frame(FFT_LEN);
    n_vec++; if (mag_if.tready !== 1'b0) begin
      n_err++; $display("FAIL tready_after_tlast case %0d: got %0b required 0", id, mag_if.tready); end
    wait_outcome(lat, rv, er);
    if (exp_bad) begin
      n_vec++; if (!er || rv) begin
        n_err++; $display("FAIL weak_frame case %0d: got err=%0b rv=%0b required 1/0", id, er, rv); end
    end else begin
      n_vec++; if (!rv || lat != LAT) begin
        n_err++; $display("FAIL latency case %0d: got rv=%0b lat=%0d required 1/%0d", id, rv, lat, LAT); end
      n_vec++; if (fre_a !== exp_fa) begin
        n_err++; $display("FAIL fre_a case %0d: got %0h required %0h", id, fre_a, exp_fa); end
      n_vec++; if (fre_b !== exp_fb) begin
        n_err++; $display("FAIL fre_b case %0d: got %0h required %0h", id, fre_b, exp_fb); end
      n_vec++; if (tri_judge !== exp_tri) begin
        n_err++; $display("FAIL tri_judge case %0d: got %0b required %0b", id, tri_judge, exp_tri); end
      n_vec++; if (power !== exp_pow) begin
        n_err++; $display("FAIL power case %0d: got %0h required %0h", id, power, exp_pow); end
      h_fa = exp_fa; h_fb = exp_fb; h_tri = exp_tri; h_pow = exp_pow;
    end
    @(posedge clk); #1;
    n_vec++; if (result_valid !== 1'b0 || frame_err !== 1'b0 || mag_if.tready !== 1'b1) begin
      n_err++; $display("FAIL pulse_end case %0d: got rv=%0b err=%0b rdy=%0b required 0/0/1",
                        id, result_valid, frame_err, mag_if.tready); end
    n_vec++; if (fre_a !== h_fa || fre_b !== h_fb || tri_judge !== h_tri || power !== h_pow) begin
      n_err++; $display("FAIL hold case %0d: got %0h/%0h required %0h/%0h", id, fre_a, fre_b, h_fa, h_fb); end
  endtask

  task automatic test_short_frame();
    int lat;
    bit rv, er;
    fill(5);
    send_frame(700);
    wait_outcome(lat, rv, er);
    n_vec++; if (!er || rv || lat != 1) begin
      n_err++; $display("FAIL short_frame_err: got err=%0b rv=%0b lat=%0d required 1/0/1", er, rv, lat); end
    @(posedge clk); #1;
    n_vec++; if (frame_err !== 1'b0 || mag_if.tready !== 1'b1) begin
      n_err++; $display("FAIL short_frame_pulse: got err=%0b rdy=%0b required 0/1", frame_err, mag_if.tready); end
    n_vec++; if (fre_a !== h_fa || fre_b !== h_fb || tri_judge !== h_tri || power !== h_pow) begin
      n_err++; $display("FAIL short_frame_hold: got %0h/%0h/%0b required %0h/%0h/%0b",
                        fre_a, fre_b, tri_judge, h_fa, h_fb, h_tri); end
  endtask

  task automatic test_low_power();
    int lat;
    bit rv, er;
    fill(5);
    for (int k = 0; k < HALF; k++) frame[k] = $urandom_range(0, 1023);
    send_frame(FFT_LEN);
    wait_outcome(lat, rv, er);
    n_vec++; if (!er || rv) begin
      n_err++; $display("FAIL low_power_err: got err=%0b rv=%0b required 1/0", er, rv); end
    @(posedge clk); #1;
    n_vec++; if (fre_a !== h_fa || fre_b !== h_fb || tri_judge !== h_tri || power !== h_pow) begin
      n_err++; $display("FAIL low_power_hold: got %0h/%0h required %0h/%0h", fre_a, fre_b, h_fa, h_fb); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    fill(0);
    send_frame(FFT_LEN);
    repeat (700) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (fre_a !== 48'd0 || fre_b !== 48'd0 || tri_judge !== 2'd0 || power !== 64'd0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %0h/%0h/%0b/%0h required 0", fre_a, fre_b, tri_judge, power); end
    n_vec++; if (mag_if.tready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_tready: got %0b required 1", mag_if.tready); end
    seen = 0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (result_valid || frame_err) seen = 1;
    end
    n_vec++; if (seen) begin
      n_err++; $display("FAIL mid_reset_no_result: got pulse=%0b required 0", seen); end
    h_fa = '0; h_fb = '0; h_tri = '0; h_pow = '0;
  endtask

  initial begin
    test_reset();
    for (int id = 0; id < 5; id++) test_peak_frame(id);
    for (int r = 0; r < 4; r++) test_peak_frame(5 + r);
    test_short_frame();
    test_low_power();
    test_reset_mid_scan();
    test_peak_frame(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
